doubly_linked_list: RTL and testbench

- Parametrised doubly linked list storage engine; successor to the team's singly linked list.
- Adds prev pointers, insert-before-address, delete-by-address, a live length count, and backward traversal via pre_node_addr.
- Node storage is register arrays with a valid bitmap; free slots are picked lowest-index-first.
- Sits behind a command/handshake interface driven by a host FSM or testbench.

---
 rtl/dll_pkg.sv | 26 ++
 rtl/dll_free_slot.sv | 23 ++
 rtl/doubly_linked_list.sv | 222 ++++++++++++++++++++++
 tb/tb_doubly_linked_list.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dll_pkg.sv
// Shared types for the doubly linked list engine: command codes, FSM states
// and the NULL pointer value for a given address width.
package dll_pkg;

  typedef enum logic [2:0] {
    OP_READ       = 3'd0,
    OP_INSERT_AT  = 3'd1,
    OP_DEL_VALUE  = 3'd2,
    OP_DEL_AT     = 3'd3,
    OP_PUSH_BACK  = 3'd4,
    OP_PUSH_FRONT = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_TRAVERSE = 3'd2,
    S_UNLINK   = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  function automatic int NULL_ADDR(input int aw);
    return (1 << aw) - 1;
  endfunction

endpackage

// File: rtl/dll_free_slot.sv
// Lowest-index free slot finder over the node valid bitmap.
module dll_free_slot #(
  parameter int MAX_NODE   = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic [MAX_NODE-1:0]   i_valid,
  output logic [ADDR_WIDTH-1:0] o_slot,
  output logic                  o_none
);

  always_comb begin
    o_slot = '0;
    o_none = 1'b1;
    // Scan downward so the lowest clear bit is the one that sticks.
    for (int i = MAX_NODE - 1; i >= 0; i--) begin
      if (!i_valid[i]) begin
        o_slot = ADDR_WIDTH'(i);
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/doubly_linked_list.sv
// Doubly linked list storage engine with register-array nodes and a
// command/handshake front end.
//   state    | meaning
//   IDLE     | waiting for op_start, captures command
//   EXEC     | validates and performs single-step ops, checks head for Delete_Value
//   TRAVERSE | walks one node per cycle looking for the Delete_Value match
//   UNLINK   | removes the matched node
//   DONE     | completes; op_done pulses as the FSM returns to IDLE
module doubly_linked_list
  import dll_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_NODE   = 8,
  localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [2:0]            op,
  input  logic                  op_start,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  op_done,
  output logic [ADDR_WIDTH-1:0] next_node_addr,
  output logic [ADDR_WIDTH-1:0] pre_node_addr,
  output logic [ADDR_WIDTH-1:0] head,
  output logic [ADDR_WIDTH-1:0] tail,
  output logic [ADDR_WIDTH-1:0] length,
  output logic                  full,
  output logic                  empty,
  output logic                  fault
);

  localparam int IDX_WIDTH = $clog2(MAX_NODE);
  localparam logic [ADDR_WIDTH-1:0] NULL_A = ADDR_WIDTH'(NULL_ADDR(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] MAX_A  = ADDR_WIDTH'(MAX_NODE);

  function automatic logic [IDX_WIDTH-1:0] ix(input logic [ADDR_WIDTH-1:0] a);
    return IDX_WIDTH'(a);
  endfunction

  state_e                r_state;
  op_e                   r_op;
  logic [DATA_WIDTH-1:0] r_din;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_cur;
  logic [DATA_WIDTH-1:0] r_data [MAX_NODE];
  logic [ADDR_WIDTH-1:0] r_next [MAX_NODE];
  logic [ADDR_WIDTH-1:0] r_prev [MAX_NODE];
  logic [MAX_NODE-1:0]   r_valid;
  logic [ADDR_WIDTH-1:0] r_head;
  logic [ADDR_WIDTH-1:0] r_tail;
  logic [ADDR_WIDTH-1:0] r_length;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [ADDR_WIDTH-1:0] r_next_out;
  logic [ADDR_WIDTH-1:0] r_prev_out;
  logic                  r_op_done;
  logic                  r_fault;

  logic [ADDR_WIDTH-1:0] w_slot;
  logic                  w_none;
  logic                  w_addr_ok;
  logic                  w_do_unlink;
  logic [ADDR_WIDTH-1:0] w_ul;
  logic [ADDR_WIDTH-1:0] w_ul_prev;
  logic [ADDR_WIDTH-1:0] w_ul_next;
  logic [ADDR_WIDTH-1:0] w_ins_prev;

  dll_free_slot #(
    .MAX_NODE   (MAX_NODE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_free_slot (
    .i_valid (r_valid),
    .o_slot  (w_slot),
    .o_none  (w_none)
  );

  assign w_addr_ok   = (r_addr < MAX_A) && r_valid[ix(r_addr)];
  assign w_ins_prev  = r_prev[ix(r_addr)];
  // Delete_At_Addr unlinks straight from EXEC; Delete_Value goes through UNLINK.
  assign w_do_unlink = (r_state == S_UNLINK) ||
                       ((r_state == S_EXEC) && (r_op == OP_DEL_AT) && w_addr_ok);
  assign w_ul        = (r_state == S_UNLINK) ? r_cur : r_addr;
  assign w_ul_prev   = r_prev[ix(w_ul)];
  assign w_ul_next   = r_next[ix(w_ul)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= OP_READ;
      r_din      <= '0;
      r_addr     <= NULL_A;
      r_cur      <= NULL_A;
      r_valid    <= '0;
      r_head     <= NULL_A;
      r_tail     <= NULL_A;
      r_length   <= '0;
      r_data_out <= '0;
      r_next_out <= NULL_A;
      r_prev_out <= NULL_A;
      r_op_done  <= 1'b0;
      r_fault    <= 1'b0;
      for (int i = 0; i < MAX_NODE; i++) begin
        r_data[i] <= '0;
        r_next[i] <= NULL_A;
        r_prev[i] <= NULL_A;
      end
    end else begin
      r_op_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (op_start) begin
            r_op    <= op_e'(op);
            r_din   <= data_in;
            r_addr  <= addr_in;
            r_fault <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state <= S_DONE;
          case (r_op)
            OP_READ: begin
              if (w_addr_ok) begin
                r_data_out <= r_data[ix(r_addr)];
                r_next_out <= r_next[ix(r_addr)];
                r_prev_out <= r_prev[ix(r_addr)];
              end else r_fault <= 1'b1;
            end
            OP_PUSH_BACK: begin
              if (w_none) r_fault <= 1'b1;
              else begin
                r_data[ix(w_slot)]  <= r_din;
                r_valid[ix(w_slot)] <= 1'b1;
                r_prev[ix(w_slot)]  <= r_tail;
                r_next[ix(w_slot)]  <= NULL_A;
                if (r_tail == NULL_A) r_head <= w_slot;
                else r_next[ix(r_tail)] <= w_slot;
                r_tail   <= w_slot;
                r_length <= r_length + 1'b1;
              end
            end
            OP_PUSH_FRONT: begin
              if (w_none) r_fault <= 1'b1;
              else begin
                r_data[ix(w_slot)]  <= r_din;
                r_valid[ix(w_slot)] <= 1'b1;
                r_prev[ix(w_slot)]  <= NULL_A;
                r_next[ix(w_slot)]  <= r_head;
                if (r_head == NULL_A) r_tail <= w_slot;
                else r_prev[ix(r_head)] <= w_slot;
                r_head   <= w_slot;
                r_length <= r_length + 1'b1;
              end
            end
            OP_INSERT_AT: begin
              if (w_none || !w_addr_ok) r_fault <= 1'b1;
              else begin
                r_data[ix(w_slot)]  <= r_din;
                r_valid[ix(w_slot)] <= 1'b1;
                r_prev[ix(w_slot)]  <= w_ins_prev;
                r_next[ix(w_slot)]  <= r_addr;
                r_prev[ix(r_addr)]  <= w_slot;
                if (w_ins_prev == NULL_A) r_head <= w_slot;
                else r_next[ix(w_ins_prev)] <= w_slot;
                r_length <= r_length + 1'b1;
              end
            end
            OP_DEL_AT: begin
              if (!w_addr_ok) r_fault <= 1'b1;
            end
            OP_DEL_VALUE: begin
              if (r_head == NULL_A) r_fault <= 1'b1;
              else if (r_data[ix(r_head)] == r_din) begin
                r_cur   <= r_head;
                r_state <= S_UNLINK;
              end else begin
                r_cur   <= r_next[ix(r_head)];
                r_state <= S_TRAVERSE;
              end
            end
            default: r_fault <= 1'b1;
          endcase
        end
        S_TRAVERSE: begin
          if (r_cur == NULL_A) begin
            r_fault <= 1'b1;
            r_state <= S_DONE;
          end else if (r_data[ix(r_cur)] == r_din) r_state <= S_UNLINK;
          else r_cur <= r_next[ix(r_cur)];
        end
        S_UNLINK: r_state <= S_DONE;
        S_DONE: begin
          r_op_done <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_do_unlink) begin
        r_valid[ix(w_ul)] <= 1'b0;
        if (w_ul_prev == NULL_A) r_head <= w_ul_next;
        else r_next[ix(w_ul_prev)] <= w_ul_next;
        if (w_ul_next == NULL_A) r_tail <= w_ul_prev;
        else r_prev[ix(w_ul_next)] <= w_ul_prev;
        r_length <= r_length - 1'b1;
      end
    end
  end

  assign data_out       = r_data_out;
  assign op_done        = r_op_done;
  assign next_node_addr = r_next_out;
  assign pre_node_addr  = r_prev_out;
  assign head           = r_head;
  assign tail           = r_tail;
  assign length         = r_length;
  assign full           = (r_length == MAX_A);
  assign empty          = (r_length == '0);
  assign fault          = r_fault;

endmodule

// File: tb/tb_doubly_linked_list.sv
// Directed bench for doubly_linked_list: hand-computed list contents,
// pointers, latencies and fault cases.
module tb_doubly_linked_list;

  localparam logic [3:0] NUL = 4'hF;
  localparam logic [2:0] RD = 3'd0, INS = 3'd1, DV = 3'd2, DA = 3'd3, PB = 3'd4, PF = 3'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic [3:0] addr_in;
  logic [2:0] op;
  logic       op_start;
  logic [7:0] data_out;
  logic       op_done;
  logic [3:0] next_node_addr;
  logic [3:0] pre_node_addr;
  logic [3:0] head;
  logic [3:0] tail;
  logic [3:0] length;
  logic       full;
  logic       empty;
  logic       fault;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  doubly_linked_list #(.DATA_WIDTH(8), .MAX_NODE(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .addr_in        (addr_in),
    .op             (op),
    .op_start       (op_start),
    .data_out       (data_out),
    .op_done        (op_done),
    .next_node_addr (next_node_addr),
    .pre_node_addr  (pre_node_addr),
    .head           (head),
    .tail           (tail),
    .length         (length),
    .full           (full),
    .empty          (empty),
    .fault          (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [3:0] a,
                        input logic [7:0] d, input int exp_lat, input logic exp_fault);
    int lat;
    @(negedge clk);
    op = o; addr_in = a; data_in = d; op_start = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0; op = 3'd7; addr_in = 4'hE; data_in = 8'hFF;
    lat = 0;
    while (!op_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " fault"}, fault, exp_fault);
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] d,
                          input logic [3:0] n, input logic [3:0] p);
    run_op(tag, RD, a, 8'h00, 2, 1'b0);
    check({tag, " data"}, data_out, d);
    check({tag, " next"}, next_node_addr, n);
    check({tag, " prev"}, pre_node_addr, p);
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, " head"}, head, NUL);
    check({tag, " tail"}, tail, NUL);
    check({tag, " length"}, length, 0);
    check({tag, " empty"}, empty, 1);
    check({tag, " full"}, full, 0);
    check({tag, " op_done"}, op_done, 0);
    check({tag, " fault"}, fault, 0);
    check({tag, " data_out"}, data_out, 0);
    check({tag, " next_out"}, next_node_addr, NUL);
    check({tag, " prev_out"}, pre_node_addr, NUL);
  endtask

  initial begin
    rst = 1'b1; op_start = 1'b0; op = 3'd0; addr_in = 4'd0; data_in = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk_reset_outputs("reset");

    // Build 0x44,0x11,0x22,0x33 in slots 3,0,1,2
    run_op("pb11", PB, 4'd0, 8'h11, 2, 1'b0);
    check("pb11 head", head, 0);
    check("pb11 tail", tail, 0);
    run_op("pb22", PB, 4'd0, 8'h22, 2, 1'b0);
    run_op("pb33", PB, 4'd0, 8'h33, 2, 1'b0);
    run_op("pf44", PF, 4'd0, 8'h44, 2, 1'b0);
    check("build head", head, 3);
    check("build tail", tail, 2);
    check("build length", length, 4);
    @(posedge clk); #1;
    check("op_done one cycle", op_done, 0);
    read_chk("rd3", 4'd3, 8'h44, 4'd0, NUL);
    read_chk("rd0", 4'd0, 8'h11, 4'd1, 4'd3);
    read_chk("rd1", 4'd1, 8'h22, 4'd2, 4'd0);
    read_chk("rd2", 4'd2, 8'h33, NUL, 4'd1);

    // Delete_Value at position 2, then slot reuse
    run_op("dv22", DV, 4'd0, 8'h22, 5, 1'b0);
    check("dv22 length", length, 3);
    read_chk("dv22 rd0", 4'd0, 8'h11, 4'd2, 4'd3);
    read_chk("dv22 rd2", 4'd2, 8'h33, NUL, 4'd0);
    run_op("pb55", PB, 4'd0, 8'h55, 2, 1'b0);
    check("pb55 tail", tail, 1);
    read_chk("pb55 rd1", 4'd1, 8'h55, NUL, 4'd2);

    // Insert before head and before a middle node
    run_op("ins66", INS, 4'd3, 8'h66, 2, 1'b0);
    check("ins66 head", head, 4);
    read_chk("ins66 rd4", 4'd4, 8'h66, 4'd3, NUL);
    read_chk("ins66 rd3", 4'd3, 8'h44, 4'd0, 4'd4);
    run_op("ins77", INS, 4'd2, 8'h77, 2, 1'b0);
    read_chk("ins77 rd5", 4'd5, 8'h77, 4'd2, 4'd0);
    read_chk("ins77 rd0", 4'd0, 8'h11, 4'd5, 4'd3);
    check("ins77 length", length, 6);

    // Fill: list 4,3,0,5,2,1,6,7
    run_op("pb88", PB, 4'd0, 8'h88, 2, 1'b0);
    run_op("pbAA", PB, 4'd0, 8'hAA, 2, 1'b0);
    check("fill full", full, 1);
    check("fill length", length, 8);
    check("fill tail", tail, 7);
    run_op("pb full", PB, 4'd0, 8'hBB, 2, 1'b1);
    check("pb full length", length, 8);
    check("pb full tail", tail, 7);
    run_op("pf full", PF, 4'd0, 8'hBB, 2, 1'b1);
    check("pf full head", head, 4);
    run_op("ins full", INS, 4'd0, 8'hCC, 2, 1'b1);
    run_op("dv nomatch", DV, 4'd0, 8'h99, 10, 1'b1);
    check("dv nomatch length", length, 8);
    check("dv nomatch head", head, 4);

    // Delete_Value at position 0
    run_op("dv66", DV, 4'd0, 8'h66, 3, 1'b0);
    check("dv66 head", head, 3);
    check("dv66 length", length, 7);
    check("dv66 full", full, 0);
    read_chk("dv66 rd3", 4'd3, 8'h44, 4'd0, NUL);

    // Address and opcode faults
    run_op("rd invalid", RD, 4'd4, 8'h00, 2, 1'b1);
    run_op("rd range", RD, 4'd8, 8'h00, 2, 1'b1);
    run_op("op6", 3'd6, 4'd0, 8'h00, 2, 1'b1);
    run_op("op7", 3'd7, 4'd0, 8'h00, 2, 1'b1);
    run_op("ins invalid", INS, 4'd4, 8'h12, 2, 1'b1);
    check("ins invalid length", length, 7);

    // Delete_At_Addr: head, tail, middles, sole node. List 3,0,5,2,1,6,7
    run_op("da head", DA, 4'd3, 8'h00, 2, 1'b0);
    check("da head head", head, 0);
    read_chk("da head rd0", 4'd0, 8'h11, 4'd5, NUL);
    run_op("da tail", DA, 4'd7, 8'h00, 2, 1'b0);
    check("da tail tail", tail, 6);
    read_chk("da tail rd6", 4'd6, 8'h88, NUL, 4'd1);
    run_op("da5", DA, 4'd5, 8'h00, 2, 1'b0);
    read_chk("da5 rd0", 4'd0, 8'h11, 4'd2, NUL);
    run_op("da2", DA, 4'd2, 8'h00, 2, 1'b0);
    run_op("da1", DA, 4'd1, 8'h00, 2, 1'b0);
    run_op("da6", DA, 4'd6, 8'h00, 2, 1'b0);
    check("sole length", length, 1);
    check("sole head", head, 0);
    check("sole tail", tail, 0);
    read_chk("sole rd0", 4'd0, 8'h11, NUL, NUL);
    run_op("da sole", DA, 4'd0, 8'h00, 2, 1'b0);
    check("da sole head", head, NUL);
    check("da sole tail", tail, NUL);
    check("da sole empty", empty, 1);
    check("da sole length", length, 0);
    run_op("da null", DA, NUL, 8'h00, 2, 1'b1);
    run_op("dv empty", DV, 4'd0, 8'h11, 2, 1'b1);

    // Reset during a Delete_Value traversal
    run_op("r pb01", PB, 4'd0, 8'h01, 2, 1'b0);
    run_op("r pb02", PB, 4'd0, 8'h02, 2, 1'b0);
    run_op("r pb03", PB, 4'd0, 8'h03, 2, 1'b0);
    read_chk("r rd2", 4'd2, 8'h03, NUL, 4'd1);
    @(negedge clk);
    op = DV; data_in = 8'h03; addr_in = 4'd0; op_start = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid traverse op_done", op_done, 0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid reset");
    @(negedge clk); rst = 1'b0;
    run_op("post pb", PB, 4'd0, 8'h5A, 2, 1'b0);
    check("post pb head", head, 0);
    check("post pb tail", tail, 0);
    check("post pb length", length, 1);
    read_chk("post rd0", 4'd0, 8'h5A, NUL, NUL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
